bare_ram: RTL and testbench
===========================

// Module: bare_ram
// PURPOSE
//  Generic true-dual-port synchronous RAM: 2**SCALE words of WIDTH bits, two independent R/W ports.
//  Registered, 1-cycle read latency; optional power-on zero fill.
//  Storage primitive under the data cache and the cache valid/tag array; infers block RAM.
// PARAMETERS
//  WIDTH  32  word width in bits (>=1; multiple of 8 when BARE_RAM_BYTE_WE_EN defined)
//  SCALE  10  address width; depth = 2**SCALE words
//  INIT   0   1: every word zero at power-on/configuration; 0: contents undefined (X in sim)
// PORTS
//  clk     in   1      single clock, all activity on rising edge
//  rst     in   1      synchronous, active-low reset
//  oe0     in   1      port 0 enable (read and write qualifier)
//  addr0   in   SCALE  port 0 word address
//  wdata0  in   WIDTH  port 0 write data
//  we0     in   WE_W   port 0 write enable (WE_W=1, or WIDTH/8 with BARE_RAM_BYTE_WE_EN)
//  rdata0  out  WIDTH  port 0 registered read data
//  oe1, addr1, wdata1, we1, rdata1: identical for port 1
// BEHAVIOUR
//  - Reset: rst==0 at a clk edge clears rdata0/rdata1 to 0; writes on both ports suppressed that cycle;
//    memory array NOT cleared by reset (only INIT affects contents).
//  - Read: oe==1 at edge N -> rdata = mem[addr] valid after edge N (usable cycle N+1).
//    oe==0 -> rdata holds its previous value (no X, no change).
//  - Write: oe==1 && we asserted at edge N -> mem[addr] <= wdata at edge N. we ignored when oe==0.
//  - Same-port read-during-write: read-first; rdata returns OLD contents, new value visible next read.
//  - Cross-port, same address, one writing: reading port returns OLD contents.
//  - Cross-port write-write same address same cycle: port 1 wins (per enabled lane with byte enables).
//  - Ports fully independent otherwise; no stalls, no handshake, throughput 1 access/port/cycle.
//  - Address is exactly SCALE bits; no wrap logic needed, callers slice their own addresses.
//  - INIT==1: initial loop writes 0 to all 2**SCALE words; first read before any write returns 0.
// CONFIGURATION
//  BARE_RAM_BYTE_WE_EN defined: we0/we1 are WIDTH/8 bits; bit i writes wdata[8*i+:8] into
//    byte lane i only; other lanes keep contents. Any bit set with oe counts as a write for collisions.
//  Not defined: we0/we1 are 1 bit; whole word written. Elaboration error if macro defined and WIDTH%8!=0.
// STRUCTURE
//  Shared package bare_ram_pkg: localparam DEPTH=2**SCALE helper, WE_W computation function,
//    collision-priority constant (PORT1_WINS). No typedefs beyond these.
//  One natural sub-module: bare_ram_port (per-port read register + write-lane decode), instanced twice;
//    array and collision priority stay in bare_ram.
//  32-bit byte-enable cache data RAM = bare_ram with WIDTH=32 and BARE_RAM_BYTE_WE_EN.
// TESTING
//  1. INIT=1, SCALE=4: read all 16 addrs on port 0 after reset release -> rdata0==0 each, 1 cycle later.
//  2. P0 write addr 5 = 0xDEADBEEF; next cycle P1 read addr 5 -> rdata1==0xDEADBEEF following cycle.
//  3. Same-port RAW: P0 write addr 3=0x11 then same-cycle read addr 3 -> old 0x0; next read -> 0x11.
//  4. Both ports write addr 7 same cycle (P0=0xAAAA, P1=0x5555) -> later read ==0x5555.
//  5. BYTE_WE_EN: word 0x01234567, we=4'b0010, wdata=0xFFFFFFFF -> read 0x0123FF67.
//  6. rdata0=0x11 held with oe0=0 for 5 cycles -> stays 0x11; rst=0 one edge -> rdata0/1==0, mem intact.

Source files
------------

// File: rtl/bare_ram_pkg.sv
// Shared constants and helpers for bare_ram.
// Build option: BARE_RAM_BYTE_WE_EN selects per-byte write enables.
package bare_ram_pkg;

    // On a same-cycle write to the same word from both ports, port 1 data is kept.
    localparam bit PORT1_WINS = 1'b1;

`ifdef BARE_RAM_BYTE_WE_EN
    localparam bit BYTE_WE_EN = 1'b1;
`else
    localparam bit BYTE_WE_EN = 1'b0;
`endif

    // Number of words for a given address width.
    function automatic int unsigned depth(input int unsigned scale);
        return 32'd1 << scale;
    endfunction

    // Width of each port's write-enable bus: one bit per byte lane, or a single bit.
    function automatic int unsigned we_width(input int unsigned width);
        return BYTE_WE_EN ? (width / 8) : 1;
    endfunction

endpackage

// File: rtl/bare_ram_port.sv
// One RAM access port: registered read data and write-lane qualification.
// Build option: BARE_RAM_BYTE_WE_EN (via WE_W) widens the lane enables.
module bare_ram_port #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WE_W  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             oe_i,
    input  logic [WE_W-1:0]  we_i,
    input  logic [WIDTH-1:0] rd_word_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WE_W-1:0]  lane_we_o
);

    logic [WIDTH-1:0] rdata_q;

    // Read register: cleared by reset, loads the addressed word when enabled, else holds.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (oe_i) begin
            rdata_q <= rd_word_i;
        end
    end

    // Lane enables: we only counts with the port enabled and out of reset.
    always_comb begin
        lane_we_o = '0;
        if (oe_i && rst_ni) begin
            lane_we_o = we_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bare_ram.sv
// True-dual-port synchronous RAM, 2**SCALE words of WIDTH bits, read-first, 1-cycle read latency.
// Build option: BARE_RAM_BYTE_WE_EN gives WIDTH/8 byte-lane write enables per port.
module bare_ram
    import bare_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SCALE = 10,
    parameter int unsigned INIT  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           oe0,
    input  logic [SCALE-1:0]               addr0,
    input  logic [WIDTH-1:0]               wdata0,
    input  logic [we_width(WIDTH)-1:0]     we0,
    output logic [WIDTH-1:0]               rdata0,
    input  logic                           oe1,
    input  logic [SCALE-1:0]               addr1,
    input  logic [WIDTH-1:0]               wdata1,
    input  logic [we_width(WIDTH)-1:0]     we1,
    output logic [WIDTH-1:0]               rdata1
);

    localparam int unsigned DEPTH  = depth(SCALE);
    localparam int unsigned WE_W   = we_width(WIDTH);
    localparam int unsigned LANE_W = WIDTH / WE_W;
    localparam logic [WIDTH-1:0] INIT_WORD = (INIT != 0) ? '0 : 'x;

`ifdef BARE_RAM_BYTE_WE_EN
    if ((WIDTH % 8) != 0) begin : g_width_check
        $error("bare_ram: WIDTH must be a multiple of 8 with byte write enables");
    end
`endif

    // Power-on contents come from the declaration; reset never touches the array.
    logic [WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [WIDTH-1:0] rd_word0, rd_word1;
    logic [WE_W-1:0]  lane_we0, lane_we1;

    // Asynchronous array lookup feeding each port's read register (read-first).
    always_comb begin
        rd_word0 = mem_q[addr0];
        rd_word1 = mem_q[addr1];
    end

    bare_ram_port #(
        .WIDTH (WIDTH),
        .WE_W  (WE_W)
    ) u_port0 (
        .clk_i     (clk),
        .rst_ni    (rst),
        .oe_i      (oe0),
        .we_i      (we0),
        .rd_word_i (rd_word0),
        .rdata_o   (rdata0),
        .lane_we_o (lane_we0)
    );

    bare_ram_port #(
        .WIDTH (WIDTH),
        .WE_W  (WE_W)
    ) u_port1 (
        .clk_i     (clk),
        .rst_ni    (rst),
        .oe_i      (oe1),
        .we_i      (we1),
        .rd_word_i (rd_word1),
        .rdata_o   (rdata1),
        .lane_we_o (lane_we1)
    );

    // Array write: later assignment wins per lane, so the preferred port is written last.
    always_ff @(posedge clk) begin
        for (int l = 0; l < WE_W; l++) begin
            if (PORT1_WINS) begin
                if (lane_we0[l]) mem_q[addr0][l*LANE_W +: LANE_W] <= wdata0[l*LANE_W +: LANE_W];
                if (lane_we1[l]) mem_q[addr1][l*LANE_W +: LANE_W] <= wdata1[l*LANE_W +: LANE_W];
            end else begin
                if (lane_we1[l]) mem_q[addr1][l*LANE_W +: LANE_W] <= wdata1[l*LANE_W +: LANE_W];
                if (lane_we0[l]) mem_q[addr0][l*LANE_W +: LANE_W] <= wdata0[l*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: tb/tb_bare_ram.sv
// Self-checking bench for bare_ram (WIDTH=32, SCALE=4, INIT=1): directed cases plus random traffic
// against a word-array reference model. Honours BARE_RAM_BYTE_WE_EN.
module tb_bare_ram;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SCALE = 4;
    localparam int unsigned WE_W  = bare_ram_pkg::we_width(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             oe0, oe1;
    logic [SCALE-1:0] addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic [WE_W-1:0]  we0, we1;
    logic [WIDTH-1:0] rdata0, rdata1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state.
    logic [WIDTH-1:0] mem_m [16];
    logic [WIDTH-1:0] exp0, exp1;

    localparam logic [WE_W-1:0] WE_ALL  = '1;
    localparam logic [WE_W-1:0] WE_NONE = '0;

    always #5 clk = ~clk;

    bare_ram #(
        .WIDTH (WIDTH),
        .SCALE (SCALE),
        .INIT  (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .oe0    (oe0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .we0    (we0),
        .rdata0 (rdata0),
        .oe1    (oe1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .we1    (we1),
        .rdata1 (rdata1)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Byte-merge of a write into a word, lane by lane.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] wd,
                                               input logic [WE_W-1:0] we);
        logic [WIDTH-1:0] r;
        int unsigned lw;
        r  = old_w;
        lw = WIDTH / WE_W;
        for (int i = 0; i < WE_W; i++) begin
            if (we[i]) begin
                for (int b = 0; b < lw; b++) r[i*lw + b] = wd[i*lw + b];
            end
        end
        return r;
    endfunction

    // One clock of stimulus on both ports, model update, and check of both read registers.
    task automatic step(input string tag, input logic r,
                        input logic o0, input logic [SCALE-1:0] a0, input logic [WIDTH-1:0] d0,
                        input logic [WE_W-1:0] w0,
                        input logic o1, input logic [SCALE-1:0] a1, input logic [WIDTH-1:0] d1,
                        input logic [WE_W-1:0] w1);
        logic [WIDTH-1:0] old0, old1;
        rst = r; oe0 = o0; addr0 = a0; wdata0 = d0; we0 = w0;
        oe1 = o1; addr1 = a1; wdata1 = d1; we1 = w1;
        @(posedge clk);
        old0 = mem_m[a0];
        old1 = mem_m[a1];
        if (!r) begin
            exp0 = '0;
            exp1 = '0;
        end else begin
            if (o0) exp0 = old0;
            if (o1) exp1 = old1;
            if (o0) mem_m[a0] = merge(mem_m[a0], d0, w0);
            if (o1) mem_m[a1] = merge(mem_m[a1], d1, w1);
        end
        #1;
        check($sformatf("%s.rdata0", tag), rdata0, exp0);
        check($sformatf("%s.rdata1", tag), rdata1, exp1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        exp0 = '0;
        exp1 = '0;

        // Reset with write attempts on both ports: writes must be dropped.
        step("reset0", 1'b0, 1'b1, 4'd1, 32'h0000_0BAD, WE_ALL, 1'b1, 4'd2, 32'h0000_0BAD, WE_ALL);
        step("reset1", 1'b0, 1'b1, 4'd1, 32'h0000_0BAD, WE_ALL, 1'b1, 4'd2, 32'h0000_0BAD, WE_ALL);
        check("reset.rdata0_zero", rdata0, 32'h0);

        // Zero fill: every word reads 0 on port 0.
        for (int a = 0; a < 16; a++) begin
            step("init_read", 1'b1, 1'b1, a[SCALE-1:0], 32'h0, WE_NONE, 1'b0, 4'd0, 32'h0, WE_NONE);
            check("init_read.zero", rdata0, 32'h0);
        end

        // Port 0 write, then port 1 read of the same word.
        step("p0wr5", 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, WE_ALL, 1'b0, 4'd0, 32'h0, WE_NONE);
        step("p1rd5", 1'b1, 1'b0, 4'd0, 32'h0, WE_NONE, 1'b1, 4'd5, 32'h0, WE_NONE);
        check("cross_port.rdata1", rdata1, 32'hDEAD_BEEF);

        // Same-port read-during-write returns the old contents first.
        step("raw_wr3", 1'b1, 1'b1, 4'd3, 32'h0000_0011, WE_ALL, 1'b0, 4'd0, 32'h0, WE_NONE);
        check("raw.old", rdata0, 32'h0);
        step("raw_rd3", 1'b1, 1'b1, 4'd3, 32'h0, WE_NONE, 1'b0, 4'd0, 32'h0, WE_NONE);
        check("raw.new", rdata0, 32'h0000_0011);

        // Hold: port 0 disabled for 5 cycles while port 1 writes word 3.
        for (int i = 0; i < 5; i++) begin
            step("hold", 1'b1, 1'b0, 4'd3, 32'hFFFF_FFFF, WE_ALL, 1'b1, 4'd3, 32'h0000_0022, WE_ALL);
            check("hold.rdata0", rdata0, 32'h0000_0011);
        end

        // Write-write collision on word 7: port 1 data survives; cross-port read sees old value.
        step("ww7", 1'b1, 1'b1, 4'd7, 32'h0000_AAAA, WE_ALL, 1'b1, 4'd7, 32'h0000_5555, WE_ALL);
        step("rd7", 1'b1, 1'b1, 4'd7, 32'h0, WE_NONE, 1'b1, 4'd3, 32'h0, WE_NONE);
        check("collision.rdata0", rdata0, 32'h0000_5555);
        check("collision.rdata1", rdata1, 32'h0000_0022);

`ifdef BARE_RAM_BYTE_WE_EN
        // Single byte-lane write leaves the other lanes intact.
        step("bwe_full", 1'b1, 1'b1, 4'd9, 32'h0123_4567, WE_ALL, 1'b0, 4'd0, 32'h0, WE_NONE);
        step("bwe_lane", 1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF, 4'b0010, 1'b0, 4'd0, 32'h0, WE_NONE);
        step("bwe_rd", 1'b1, 1'b1, 4'd9, 32'h0, WE_NONE, 1'b0, 4'd0, 32'h0, WE_NONE);
        check("byte_we.rdata0", rdata0, 32'h0123_FF67);
`endif

        // One reset edge clears read data but not the array.
        step("rst_pulse", 1'b0, 1'b1, 4'd5, 32'h0, WE_ALL, 1'b1, 4'd7, 32'h0, WE_ALL);
        check("rst_pulse.rdata0", rdata0, 32'h0);
        check("rst_pulse.rdata1", rdata1, 32'h0);
        step("post_rst", 1'b1, 1'b1, 4'd5, 32'h0, WE_NONE, 1'b1, 4'd7, 32'h0, WE_NONE);
        check("post_rst.mem5", rdata0, 32'hDEAD_BEEF);
        check("post_rst.mem7", rdata1, 32'h0000_5555);

        // Random traffic on a small address space to force frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            step("rand", ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0), SCALE'($urandom), $urandom, WE_W'($urandom),
                 ($urandom_range(0, 3) != 0), SCALE'($urandom), $urandom, WE_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
